sparsity_mem_banked: RTL and testbench



---
 rtl/sparsity_mem_pkg.sv | 30 +++
 rtl/sparsity_mem_banked_if.sv | 28 ++
 rtl/SRAM_parametrizable_s_equivalent.sv | 24 ++
 rtl/sparsity_mem_bank.sv | 36 +++
 rtl/sparsity_mem_banked.sv | 148 ++++++++++++++
 tb/tb_sparsity_mem_banked.sv | 246 ++++++++++++++++++++++++
 6 files changed

// File: rtl/sparsity_mem_pkg.sv
// Shared types, default sizes and address-split helpers for the banked sparsity-index memory.
package sparsity_mem_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_BANK_DEPTH = 1024;
  localparam int unsigned DEF_N_BANKS    = 2;
  localparam int unsigned DEF_STARVE_MAX = 4;
  localparam int unsigned DEF_ADDR_W     = $clog2(DEF_BANK_DEPTH) + $clog2(DEF_N_BANKS);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

  // Where the word presented on rd_data_o comes from in the cycle after a grant.
  typedef enum logic [1:0] {
    RD_SRAM = 2'd0,
    RD_HOLD = 2'd1,
    RD_BYP  = 2'd2
  } rd_src_e;

  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned idx_w);
    return addr >> idx_w;
  endfunction

  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned idx_w);
    return addr & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sparsity_mem_banked_if.sv
// Loader write port and MAC-datapath read port of the banked sparsity memory.
interface sparsity_mem_banked_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  // Write: a word transfers on a clk edge where wr_valid_i && wr_ready_o; the master keeps
  // addr/data stable while valid is high and ready is low. Read: rd_req_i is granted in the
  // same cycle via rd_gnt_o; rd_valid_o pulses one cycle after the grant with rd_data_o.
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_req_i;
  logic              rd_gnt_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
    input  wr_ready_o, rd_gnt_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
    output wr_ready_o, rd_gnt_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/SRAM_parametrizable_s_equivalent.sv
// Behavioural single-port SRAM macro: active-low CEB/WEB, registered Q updated only on reads.
module SRAM_parametrizable_s_equivalent #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  scan_en_in
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (!CEB && !scan_en_in) begin
      if (!WEB) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end

endmodule

// File: rtl/sparsity_mem_bank.sv
// One sparsity-memory bank: maps sel/we onto the macro's active-low controls, idles address at 0.
module sparsity_mem_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              scan_en,
  input  logic              sel,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);

  logic             ceb;
  logic             web;
  logic [IDX_W-1:0] addr;

  assign ceb  = !sel;
  assign web  = !we;
  assign addr = sel ? idx : '0;

  SRAM_parametrizable_s_equivalent #(
    .DATA_WIDTH(DATA_W),
    .ADDR_WIDTH(IDX_W)
  ) u_sram (
    .CLK       (clk),
    .CEB       (ceb),
    .WEB       (web),
    .A         (addr),
    .D         (data),
    .Q         (q),
    .scan_en_in(scan_en)
  );

endmodule

// File: rtl/sparsity_mem_banked.sv
// Banked sparsity-index memory: write buffer, read/write bank arbitration, re-read suppression.
// Optional SPARSITY_MEM_RD_BYPASS_EN forwards a pending buffered write to a matching read.
module sparsity_mem_banked
  import sparsity_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int unsigned N_BANKS    = DEF_N_BANKS,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en_in,
  input  logic [15:0]          CONF_STR_SPARSITY,
  sparsity_mem_banked_if.slave bus,
  output logic [N_BANKS-1:0]   dbg_ceb
);

  localparam int unsigned IDX_W  = $clog2(BANK_DEPTH);
  localparam int unsigned BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned ADDR_W = IDX_W + $clog2(N_BANKS);
  localparam int unsigned CNT_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_t;

  logic              wbuf_valid;
  wbuf_t             wbuf;
  logic [CNT_W-1:0]  starve_cnt;
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_addr;
  logic              rd_valid_q;
  rd_src_e           rd_src_q;
  logic [BANK_W-1:0] rd_bank_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] data_q;

  logic              rd_en_eff, same_bank, force_wr, wr_issue, wr_accept;
  logic              rd_gnt, byp_hit, reuse, rd_sram;
  logic [BANK_W-1:0] rd_bank, wb_bank, tag_bank;
  logic [IDX_W-1:0]  rd_idx, wb_idx;
  logic [N_BANKS-1:0] rd_sel, wr_sel;
  logic [DATA_W-1:0] bank_q [N_BANKS];
  logic [DATA_W-1:0] rd_data_fresh;

  assign rd_bank  = BANK_W'(bank_of(32'(bus.rd_addr_i), IDX_W));
  assign rd_idx   = IDX_W'(idx_of(32'(bus.rd_addr_i), IDX_W));
  assign wb_bank  = BANK_W'(bank_of(32'(wbuf.addr), IDX_W));
  assign wb_idx   = IDX_W'(idx_of(32'(wbuf.addr), IDX_W));
  assign tag_bank = BANK_W'(bank_of(32'(tag_addr), IDX_W));

  // Same-bank contention: the read wins until the buffered write has lost STARVE_MAX times.
  assign rd_en_eff = bus.rd_req_i && (CONF_STR_SPARSITY != 16'd0);
  assign same_bank = wbuf_valid && rd_en_eff && (rd_bank == wb_bank);
  assign force_wr  = same_bank && (starve_cnt == CNT_W'(STARVE_MAX));
  assign wr_issue  = wbuf_valid && (!same_bank || force_wr);
  assign rd_gnt    = rd_en_eff && !force_wr;

`ifdef SPARSITY_MEM_RD_BYPASS_EN
  assign byp_hit = rd_gnt && wbuf_valid && (bus.rd_addr_i == wbuf.addr);
`else
  assign byp_hit = 1'b0;
`endif

  assign reuse   = rd_gnt && !byp_hit && tag_valid && (bus.rd_addr_i == tag_addr);
  assign rd_sram = rd_gnt && !reuse && !byp_hit;

  assign wr_accept      = bus.wr_valid_i && bus.wr_ready_o;
  assign bus.wr_ready_o = !wbuf_valid || wr_issue;
  assign bus.rd_gnt_o   = rd_gnt;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_fresh;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    assign wr_sel[b]  = wr_issue && (wb_bank == BANK_W'(b));
    assign rd_sel[b]  = rd_sram && (rd_bank == BANK_W'(b));
    assign dbg_ceb[b] = !(wr_sel[b] || rd_sel[b]);

    sparsity_mem_bank #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk    (clk),
      .scan_en(scan_en_in),
      .sel    (wr_sel[b] || rd_sel[b]),
      .we     (wr_sel[b]),
      .idx    (wr_sel[b] ? wb_idx : rd_idx),
      .data   (wbuf.data),
      .q      (bank_q[b])
    );
  end

  // The output word is held in data_q and only replaced in a rd_valid_o cycle.
  always_comb begin
    rd_data_fresh = data_q;
    if (rd_valid_q) begin
      case (rd_src_q)
        RD_SRAM: rd_data_fresh = bank_q[rd_bank_q];
        RD_BYP:  rd_data_fresh = byp_data_q;
        default: rd_data_fresh = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbuf_valid <= 1'b0;
      wbuf       <= '0;
      starve_cnt <= '0;
      tag_valid  <= 1'b0;
      tag_addr   <= '0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= RD_SRAM;
      rd_bank_q  <= '0;
      byp_data_q <= '0;
      data_q     <= '0;
    end else begin
      if (wr_accept) begin
        wbuf_valid <= 1'b1;
        wbuf       <= '{addr: bus.wr_addr_i, data: bus.wr_data_i};
      end else if (wr_issue) begin
        wbuf_valid <= 1'b0;
      end

      if (wr_issue)       starve_cnt <= '0;
      else if (same_bank) starve_cnt <= starve_cnt + CNT_W'(1);

      // A read and a write never hit the same bank in one cycle, so the order here is safe.
      if (rd_sram) begin
        tag_valid <= 1'b1;
        tag_addr  <= bus.rd_addr_i;
      end else if (wr_issue && tag_valid && (tag_bank == wb_bank)) begin
        tag_valid <= 1'b0;
      end

      rd_valid_q <= rd_gnt;
      if (rd_gnt) begin
        rd_src_q  <= byp_hit ? RD_BYP : (reuse ? RD_HOLD : RD_SRAM);
        rd_bank_q <= rd_bank;
      end
      if (byp_hit) byp_data_q <= wbuf.data;
      data_q <= rd_data_fresh;
    end
  end

endmodule

// File: tb/tb_sparsity_mem_banked.sv
// Directed bench for sparsity_mem_banked: hand-computed expectations checked by immediate assertions.
module tb_sparsity_mem_banked;

  logic        clk;
  logic        reset;
  logic        scan_en_in;
  logic [15:0] conf;
  logic [1:0]  dbg_ceb;

  int n_checks = 0;
  int n_fail   = 0;

  sparsity_mem_banked_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  sparsity_mem_banked dut (
    .clk              (clk),
    .reset            (reset),
    .scan_en_in       (scan_en_in),
    .CONF_STR_SPARSITY(conf),
    .bus              (bus),
    .dbg_ceb          (dbg_ceb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic write_word(input logic [10:0] a, input logic [31:0] d, input logic [1:0] ceb);
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = a;
    bus.wr_data_i  = d;
    #1;
    chk("wr_ready_accept", 32'(bus.wr_ready_o), 32'd1);
    tick();
    bus.wr_valid_i = 1'b0;
    #1;
    chk("wr_issue_ceb", 32'(dbg_ceb), 32'(ceb));
    tick();
  endtask

  task automatic read_word(input logic [10:0] a, input logic [31:0] exp, input logic [1:0] ceb);
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = a;
    #1;
    chk("rd_gnt", 32'(bus.rd_gnt_o), 32'd1);
    chk("rd_ceb", 32'(dbg_ceb), 32'(ceb));
    tick();
    bus.rd_req_i = 1'b0;
    #1;
    chk("rd_valid", 32'(bus.rd_valid_o), 32'd1);
    chk("rd_data", bus.rd_data_o, exp);
  endtask

  initial begin
    reset          = 1'b0;
    scan_en_in     = 1'b0;
    conf           = 16'd1;
    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.rd_req_i   = 1'b0;
    bus.rd_addr_i  = '0;

    // reset state
    tick();
    tick();
    chk("rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
    chk("rst_rd_gnt", 32'(bus.rd_gnt_o), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("rst_rd_data", bus.rd_data_o, 32'd0);
    chk("rst_ceb", 32'(dbg_ceb), 32'd3);
    reset = 1'b1;
    tick();

    // write then read, both banks
    write_word(11'h005, 32'hDEADBEEF, 2'b10);
    read_word(11'h005, 32'hDEADBEEF, 2'b10);
    tick();
    chk("rd_valid_pulse", 32'(bus.rd_valid_o), 32'd0);
    chk("rd_data_hold", bus.rd_data_o, 32'hDEADBEEF);
    write_word(11'h405, 32'h12345678, 2'b01);
    read_word(11'h405, 32'h12345678, 2'b01);

    // reads disabled by config; writes still land
    conf          = 16'd0;
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = 11'h005;
    #1;
    chk("cfg0_gnt", 32'(bus.rd_gnt_o), 32'd0);
    chk("cfg0_ceb", 32'(dbg_ceb), 32'd3);
    tick();
    chk("cfg0_valid", 32'(bus.rd_valid_o), 32'd0);
    bus.rd_addr_i = 11'h006;
    write_word(11'h006, 32'hCAFEF00D, 2'b10);
    chk("cfg0_valid_after_wr", 32'(bus.rd_valid_o), 32'd0);
    bus.rd_req_i = 1'b0;
    conf         = 16'd1;
    read_word(11'h006, 32'hCAFEF00D, 2'b10);

    // starvation guard: write to bank 0 forced on 5th contended cycle
    for (int c = 0; c < 6; c++) begin
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = (c % 2 == 1) ? 11'h006 : 11'h005;
      if (c == 0) begin
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 11'h007;
        bus.wr_data_i  = 32'h77777777;
      end
      #1;
      chk("starve_gnt", 32'(bus.rd_gnt_o), (c == 5) ? 32'd0 : 32'd1);
      if (c >= 1) chk("starve_wr_ready", 32'(bus.wr_ready_o), (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) chk("starve_force_ceb", 32'(dbg_ceb), 32'd2);
      tick();
      bus.wr_valid_i = 1'b0;
    end
    bus.rd_req_i = 1'b0;
    #1;
    chk("starve_no_valid", 32'(bus.rd_valid_o), 32'd0);
    tick();
    read_word(11'h007, 32'h77777777, 2'b10);

    // bank-1 writes stream under continuous bank-0 reads
    for (int c = 0; c < 3; c++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_addr_i  = 11'(11'h410 + c);
      bus.wr_data_i  = 32'hB0000000 + 32'(c);
      bus.rd_req_i   = 1'b1;
      bus.rd_addr_i  = (c % 2 == 1) ? 11'h006 : 11'h005;
      #1;
      chk("stream_ready", 32'(bus.wr_ready_o), 32'd1);
      chk("stream_ceb", 32'(dbg_ceb), (c == 0) ? 32'd2 : 32'd0);
      tick();
    end
    bus.wr_valid_i = 1'b0;
    bus.rd_req_i   = 1'b0;
    #1;
    chk("stream_last_ceb", 32'(dbg_ceb), 32'd1);
    chk("stream_rd_valid", 32'(bus.rd_valid_o), 32'd1);
    tick();
    read_word(11'h411, 32'hB0000001, 2'b01);

    // redundant re-read suppression
    write_word(11'h010, 32'h10101010, 2'b10);
    for (int r = 0; r < 3; r++) begin
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 11'h010;
      #1;
      chk("reread_gnt", 32'(bus.rd_gnt_o), 32'd1);
      chk("reread_ceb", 32'(dbg_ceb), (r == 0) ? 32'd2 : 32'd3);
      if (r > 0) begin
        chk("reread_valid", 32'(bus.rd_valid_o), 32'd1);
        chk("reread_data", bus.rd_data_o, 32'h10101010);
      end
      tick();
    end
    bus.rd_req_i = 1'b0;
    #1;
    chk("reread_last_valid", 32'(bus.rd_valid_o), 32'd1);
    chk("reread_last_data", bus.rd_data_o, 32'h10101010);
    tick();
    write_word(11'h011, 32'h11111111, 2'b10);
    read_word(11'h010, 32'h10101010, 2'b10);

    // reset while the buffer holds a word and a read is in flight
    tick();
    write_word(11'h030, 32'h30303030, 2'b10);
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 11'h030;
    bus.wr_data_i  = 32'hBADBAD00;
    bus.rd_req_i   = 1'b1;
    bus.rd_addr_i  = 11'h010;
    tick();
    bus.wr_valid_i = 1'b0;
    bus.rd_req_i   = 1'b0;
    reset          = 1'b0;
    #1;
    chk("midrst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
    chk("midrst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("midrst_rd_data", bus.rd_data_o, 32'd0);
    chk("midrst_ceb", 32'(dbg_ceb), 32'd3);
    tick();
    reset = 1'b1;
    tick();
    read_word(11'h030, 32'h30303030, 2'b10);

    // read of an address still waiting in the write buffer
    tick();
    write_word(11'h020, 32'h20202020, 2'b10);
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 11'h020;
    bus.wr_data_i  = 32'hA5A5A5A5;
    bus.rd_req_i   = 1'b1;
    bus.rd_addr_i  = 11'h010;
    #1;
    chk("raw_first_gnt", 32'(bus.rd_gnt_o), 32'd1);
    tick();
    bus.wr_valid_i = 1'b0;
    bus.rd_addr_i  = 11'h020;
    #1;
    chk("raw_gnt", 32'(bus.rd_gnt_o), 32'd1);
    chk("raw_wr_blocked", 32'(bus.wr_ready_o), 32'd0);
`ifdef SPARSITY_MEM_RD_BYPASS_EN
    chk("raw_ceb", 32'(dbg_ceb), 32'd3);
`else
    chk("raw_ceb", 32'(dbg_ceb), 32'd2);
`endif
    tick();
    bus.rd_req_i = 1'b0;
    #1;
    chk("raw_valid", 32'(bus.rd_valid_o), 32'd1);
`ifdef SPARSITY_MEM_RD_BYPASS_EN
    chk("raw_data", bus.rd_data_o, 32'hA5A5A5A5);
`else
    chk("raw_data", bus.rd_data_o, 32'h20202020);
`endif
    chk("raw_wr_issue_ceb", 32'(dbg_ceb), 32'd2);
    tick();
    read_word(11'h020, 32'hA5A5A5A5, 2'b10);

    // report
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
